controllore_serializzatore: RTL



---
 rtl/serializzatore_pkg.sv | 12 +
 rtl/registro_carica_trasla.sv | 19 +
 rtl/controllore_serializzatore.sv | 88 ++++++++
 3 files changed

// File: rtl/serializzatore_pkg.sv
// serializzatore_pkg: shared state encoding, default width and register command codes
package serializzatore_pkg;
  typedef enum logic [1:0] {
    ATTESA = 2'd0,
    TRASLA = 2'd1,
    PARITA = 2'd2,
    FINE   = 2'd3
  } stato_t;
  localparam int W_DEF = 4;
  localparam logic CARICA = 1'b0;
  localparam logic TRASLA_SX = 1'b1;
endpackage

// File: rtl/registro_carica_trasla.sv
// registro_carica_trasla: W-bit load / shift-left register
// Ports: clock, reset (sync, active-high), en (write enable), b0 (0 = load x, 1 = shift left inserting 0), x (parallel in), z (contents)
module registro_carica_trasla
  import serializzatore_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         b0,
  input  logic [W-1:0] x,
  output logic [W-1:0] z
);
  logic [W-1:0] z_q, z_d;
  always_comb z_d = !en ? z_q : (b0 == TRASLA_SX) ? {z_q[W-2:0], 1'b0} : x;
  always_ff @(posedge clock) z_q <= reset ? '0 : z_d;
  assign z = z_q;
endmodule

// File: rtl/controllore_serializzatore.sv
// controllore_serializzatore: sequences one load and W shifts of the register, MSB first on sout, with soc/eoc handshake
// Ports: clock, reset (sync, active-high), soc (start request), x (parallel word),
//        eoc (1 = idle/done), sout (serial bit), sout_valid, b0 (register command)
// Macro SERIALIZZATORE_PARITA_EN appends an even-parity bit after the data.
module controllore_serializzatore
  import serializzatore_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         soc,
  input  logic [W-1:0] x,
  output logic         eoc,
  output logic         sout,
  output logic         sout_valid,
  output logic         b0
);
  localparam int CW = $clog2(W);
  stato_t stato_q, stato_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic en;
  logic ultimo;
  logic [W-1:0] z;
`ifdef SERIALIZZATORE_PARITA_EN
  logic par_q, par_d;
  localparam stato_t DOPO_DATI = PARITA;
`else
  localparam stato_t DOPO_DATI = FINE;
`endif
  registro_carica_trasla #(.W(W)) u_registro (
    .clock(clock),
    .reset(reset),
    .en(en),
    .b0(b0),
    .x(x),
    .z(z)
  );
  assign ultimo = cnt_q == CW'(W - 1);
  always_comb begin
    stato_d = stato_q;
    cnt_d = cnt_q;
    en = 1'b0;
    b0 = CARICA;
`ifdef SERIALIZZATORE_PARITA_EN
    par_d = par_q;
`endif
    case (stato_q)
      ATTESA: if (soc) begin
        stato_d = TRASLA;
        cnt_d = '0;
        en = 1'b1;
`ifdef SERIALIZZATORE_PARITA_EN
        par_d = 1'b0;
`endif
      end
      TRASLA: begin
        b0 = TRASLA_SX;
        en = 1'b1;
        cnt_d = ultimo ? '0 : cnt_q + 1'b1;
        stato_d = ultimo ? DOPO_DATI : TRASLA;
`ifdef SERIALIZZATORE_PARITA_EN
        par_d = par_q ^ z[W-1];
`endif
      end
      PARITA: stato_d = FINE;
      FINE: stato_d = soc ? FINE : ATTESA;
      default: stato_d = ATTESA;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      stato_q <= ATTESA;
      cnt_q <= '0;
    end else begin
      stato_q <= stato_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef SERIALIZZATORE_PARITA_EN
  always_ff @(posedge clock) par_q <= reset ? 1'b0 : par_d;
  assign sout = (stato_q == TRASLA) ? z[W-1] : (stato_q == PARITA) ? par_q : 1'b0;
`else
  assign sout = (stato_q == TRASLA) ? z[W-1] : 1'b0;
`endif
  assign eoc = (stato_q == ATTESA) || (stato_q == FINE);
  assign sout_valid = !eoc;
endmodule
